fifo_uart_tx: RTL

- Read-side consumer of the 8-bit push/pop FIFO.
- Pops bytes from the FIFO read port and serializes each one as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits between the FIFO instance and the serial pin.
- Honours the FIFO read contract: never pops while the FIFO reports empty.

---
 rtl/fifo_uart_tx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-fed UART transmitter
//
// Purpose: pops bytes from a show-ahead 8-bit FIFO and shifts each one out as
// an asynchronous frame: start bit, 8 data bits LSB first, optional parity,
// then 1 or 2 stop bits. Back-to-back frames carry no idle gap.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   enable          allows new frames to start; a running frame always finishes
//   fifo_is_empty   FIFO empty flag
//   fifo_read_data  FIFO head byte, valid while fifo_is_empty is low
//   fifo_read_ctrl  pop strobe (combinational), FIFO advances on that edge
//   tx_out          registered serial line, idles high
//   busy            high from the cycle after a pop through the last stop cycle
//   byte_done       one-cycle pulse in the cycle after the last stop cycle
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_is_empty,
  input  logic [7:0] fifo_read_data,
  output logic       fifo_read_ctrl,
  output logic       tx_out,
  output logic       busy,
  output logic       byte_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic        ODD_PAR   = (PARITY == 2);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic bit_end;
  logic frame_end;
  logic pop;

  assign bit_end   = (baud_q == LAST_TICK);
  // Last cycle of the last stop bit: the only mid-frame point a new pop may occur.
  assign frame_end = (state_q == S_STOP) && bit_end && (bit_idx_q == LAST_STOP);
  assign pop       = enable & ~fifo_is_empty & ~rst & ((state_q == S_IDLE) | frame_end);

  assign fifo_read_ctrl = pop;
  assign tx_out         = tx_q;
  assign busy           = busy_q;
  assign byte_done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // tx_d always carries the value of the bit being entered, so tx_out lines
  // up with the state one cycle later without extra decode.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_idx_d = 3'd0;
          tx_d      = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_STOP) begin
            state_d   = S_IDLE;
            bit_idx_d = 3'd0;
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // A pop overrides the end-of-frame return to idle, chaining frames.
    if (pop) begin
      state_d   = S_START;
      baud_d    = 16'd0;
      bit_idx_d = 3'd0;
      shift_d   = fifo_read_data;
      parity_d  = (^fifo_read_data) ^ ODD_PAR;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

endmodule
